// File: rtl/mux8_sched_pkg.sv
// Shared definitions for the mux8 round-robin scheduler.
//   N_REQ  : number of requesters sharing the bit-select datapath
//   SEL_W  : width of the mux select / requester index
//   CNT_W  : width of the per-grant cycle counter
//   state_t: scheduler FSM states
package mux8_sched_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

endpackage : mux8_sched_pkg

// File: rtl/mux8_rr_sched_if.sv
// Bus between the requester bank and the scheduler.
//   req    : request vector, bit k = requester k
//   data_i : data bits, bit k = requester k
//   sel    : registered mux select (index of the owner)
//   gnt    : registered one-hot grant
//   valid  : registered, high while a grant is active
//   out    : shared output line, data_i[sel] gated by valid
// master = requester bank side, slave = scheduler side.
interface mux8_rr_sched_if;
  import mux8_sched_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] data_i;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] gnt;
  logic             valid;
  logic             out;

  modport master (
    output req,
    output data_i,
    input  sel,
    input  gnt,
    input  valid,
    input  out
  );

  modport slave (
    input  req,
    input  data_i,
    output sel,
    output gnt,
    output valid,
    output out
  );

endinterface : mux8_rr_sched_if

// File: rtl/mux8_rr_sched_rr_pick8.sv
// Combinational rotate-priority picker.
//   req : request vector
//   ptr : index at which the search starts
//   any : high when at least one request is present
//   idx : first requesting index scanning ptr, ptr+1, ... modulo 8
module rr_pick8
  import mux8_sched_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] w_cand;

  // Scan offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    any    = |req;
    idx    = ptr;
    w_cand = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      // 3-bit addition gives the modulo-8 wrap for free.
      w_cand = ptr + SEL_W'(i);
      if (req[w_cand]) begin
        idx = w_cand;
      end else begin
        idx = idx;
      end
    end
  end

endmodule : rr_pick8

// File: rtl/mux8_rr_sched.sv
// Round-robin scheduler sharing an 8:1 bit-select datapath.
//   HOLD_MAX : maximum consecutive cycles per grant (1..16)
//   clk      : rising-edge clock
//   rst_n    : asynchronous active-low reset
//   bus      : slave side of mux8_rr_sched_if (req/data_i in,
//              sel/gnt/valid/out out)
// A grant ends when the owner drops its request or has held the mux for
// HOLD_MAX cycles; the next winner is loaded on the same edge, so there is
// no idle cycle between back-to-back grants.
module mux8_rr_sched
  import mux8_sched_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  mux8_rr_sched_if.slave    bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_MAX - 1);

  state_t           r_state;
  logic [SEL_W-1:0] r_sel;
  logic [N_REQ-1:0] r_gnt;
  logic             r_valid;
  logic [SEL_W-1:0] r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic             w_any;
  logic [SEL_W-1:0] w_idx;
  logic             w_release;
  logic             w_mux;
  logic             w_out;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (r_ptr),
    .any (w_any),
    .idx (w_idx)
  );

  assign w_release = ~bus.req[r_sel] | (r_cnt == HOLD_LAST);

  // Scheduler FSM: grant bookkeeping and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_sel   <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_state <= S_GRANT;
            r_gnt   <= N_REQ'(1) << w_idx;
            r_sel   <= w_idx;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_ptr   <= w_idx + SEL_W'(1);
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_GRANT: begin
          if (!w_release) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else if (w_any) begin
            // A lone owner is found again by the wrapped search and
            // regranted with a fresh count.
            r_state <= S_GRANT;
            r_gnt   <= N_REQ'(1) << w_idx;
            r_sel   <= w_idx;
            r_valid <= 1'b1;
            r_cnt   <= '0;
            r_ptr   <= w_idx + SEL_W'(1);
          end else begin
            // sel and ptr intentionally keep their values.
            r_state <= S_IDLE;
            r_gnt   <= '0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_gnt   <= '0;
          r_valid <= 1'b0;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  // Shared 8:1 bit-select mux driven by the registered select.
  always @(*) begin
    w_mux = 1'b0;
    case (r_sel)
      3'd0:    w_mux = bus.data_i[0];
      3'd1:    w_mux = bus.data_i[1];
      3'd2:    w_mux = bus.data_i[2];
      3'd3:    w_mux = bus.data_i[3];
      3'd4:    w_mux = bus.data_i[4];
      3'd5:    w_mux = bus.data_i[5];
      3'd6:    w_mux = bus.data_i[6];
      3'd7:    w_mux = bus.data_i[7];
      default: w_mux = 1'b0;
    endcase
  end

  assign w_out     = r_valid & w_mux;
  assign bus.sel   = r_sel;
  assign bus.gnt   = r_gnt;
  assign bus.valid = r_valid;
  assign bus.out   = w_out;

endmodule : mux8_rr_sched

// File: tb/tb_mux8_rr_sched.sv
// Directed, scoreboard-based bench for mux8_rr_sched (HOLD_MAX = 4).
module tb_mux8_rr_sched;

  typedef struct {
    string      tag;
    logic [7:0] gnt;
    logic [2:0] sel;
    logic       valid;
    logic       out;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_checks;
  exp_t sb[$];

  mux8_rr_sched_if bus ();

  mux8_rr_sched #(.HOLD_MAX(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    n_checks++;
    assert (obs === expv) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] d, input logic [7:0] eg,
                      input logic [2:0] es, input logic ev);
    exp_t e;
    e.tag   = tag;
    e.gnt   = eg;
    e.sel   = es;
    e.valid = ev;
    e.out   = ev ? d[es] : 1'b0;
    sb.push_back(e);
  endtask

  task automatic compare_head();
    exp_t e;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 8'd1, 8'd0);
    end else begin
      e = sb.pop_front();
      chk({e.tag, ".gnt"},   bus.gnt,          e.gnt);
      chk({e.tag, ".sel"},   {5'd0, bus.sel},  {5'd0, e.sel});
      chk({e.tag, ".valid"}, {7'd0, bus.valid}, {7'd0, e.valid});
      chk({e.tag, ".out"},   {7'd0, bus.out},  {7'd0, e.out});
    end
  endtask

  // Drive one cycle of inputs, then check outputs after the edge.
  task automatic step(input logic [7:0] r, input logic [7:0] d, input logic [7:0] eg,
                      input logic [2:0] es, input logic ev, input string tag);
    bus.req    = r;
    bus.data_i = d;
    push(tag, d, eg, es, ev);
    @(posedge clk);
    #1;
    compare_head();
  endtask

  initial begin
    n_pass     = 0;
    n_checks   = 0;
    rst_n      = 1'b0;
    bus.req    = 8'h00;
    bus.data_i = 8'h00;

    #2;
    push("reset", 8'h00, 8'h00, 3'd0, 1'b0);
    #1;
    compare_head();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    step(8'h00, 8'hA5, 8'h00, 3'd0, 1'b0, "idle0");

    // Full contention: 4 cycles per owner, 0..7, then back to 0.
    for (int i = 0; i < 33; i++) begin
      step(8'hFF, 8'hA5, 8'h01 << ((i / 4) % 8), 3'((i / 4) % 8), 1'b1, "contend");
    end

    // Early release from 2 to 5.
    step(8'h24, 8'hA5, 8'h04, 3'd2, 1'b1, "early_grant");
    step(8'h24, 8'hA5, 8'h04, 3'd2, 1'b1, "early_hold");
    step(8'h20, 8'hA5, 8'h20, 3'd5, 1'b1, "early_switch");

    // Idle return; out stays 0 whatever data_i is.
    step(8'h00, 8'hA5, 8'h00, 3'd5, 1'b0, "idle_ret");
    step(8'h00, 8'hFF, 8'h00, 3'd5, 1'b0, "idle_out");
    step(8'h10, 8'hFF, 8'h10, 3'd4, 1'b1, "idle_regrant");

    // Owner 1 with data 0xA5 -> out 0.
    step(8'h02, 8'hA5, 8'h02, 3'd1, 1'b1, "data_sel1");

    // Lone requester 3 is regranted without a gap.
    for (int i = 0; i < 12; i++) begin
      step(8'h08, 8'h08, 8'h08, 3'd3, 1'b1, "lone");
    end

    // Owner 7 exhausts its hold; search wraps to 0.
    for (int i = 0; i < 4; i++) begin
      step(8'h80, 8'hA5, 8'h80, 3'd7, 1'b1, "owner7");
    end
    step(8'h81, 8'hA5, 8'h01, 3'd0, 1'b1, "wrap_81");

    // Reset in the middle of a grant to 5.
    step(8'h20, 8'hFF, 8'h20, 3'd5, 1'b1, "pre_reset");
    #2;
    rst_n = 1'b0;
    push("mid_reset", 8'hFF, 8'h00, 3'd0, 1'b0);
    #1;
    compare_head();
    #1;
    rst_n = 1'b1;
    step(8'h01, 8'hFF, 8'h01, 3'd0, 1'b1, "post_reset");
    step(8'h01, 8'hFF, 8'h01, 3'd0, 1'b1, "post_hold");

    if (sb.size() != 0) begin
      chk("scoreboard_left", 8'(sb.size()), 8'd0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_mux8_rr_sched

// File: doc/mux8_rr_sched.md
# mux8_rr_sched

Round-robin scheduler that shares the 8:1 bit-select datapath among eight requesters. Each requester raises a request line. The block grants one requester at a time, drives the 3-bit mux select, and forwards the granted requester's data bit to the shared output. A grant is held for a bounded number of cycles so that no requester can starve the others. The block sits between the requester bank and the shared serial output line.

## Interface
- HOLD_MAX, 4: maximum consecutive cycles per grant; legal range 1..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  8  request vector; bit k belongs to requester k.
- data_i  input  8  data bits; bit k belongs to requester k.
- sel  output  3  registered mux select; equals the index of the granted requester.
- gnt  output  8  registered one-hot grant; all zeros when nothing is granted.
- valid  output  1  registered; 1 while any grant is active.
- out  output  1  shared output line: data_i[sel] when valid=1, else 0 (combinational from registered sel/valid).

## Operation
- State machine with two states.
  - IDLE: no grant.
  - GRANT: one requester owns the mux.
- Internal registers:
  - ptr (3 bits): search start position.
  - cnt (4 bits): cycles elapsed in the current grant.
- Winner selection: the first k with req[k]=1, scanning ptr, ptr+1, … modulo 8 with 3-bit wrap (7 wraps to 0).
- IDLE:
  - If req≠0, go to GRANT. Load gnt=1<<winner, sel=winner, valid=1, cnt=0, ptr=winner+1.
  - Otherwise stay in IDLE.
- GRANT, with release = (req[sel]==0) or (cnt==HOLD_MAX-1):
  - No release: cnt increments; sel, gnt and ptr hold.
  - Release with req≠0: pick a new winner from ptr and load it exactly as in IDLE. There is no idle cycle between grants.
  - Release with req==0: go to IDLE with gnt=0, valid=0. sel and ptr hold.
- If the current owner is the only requester, the search wraps back to it. It is regranted with cnt reset to 0, and gnt stays asserted with no gap.
- HOLD_MAX=1: every grant lasts one cycle, giving strict per-cycle rotation.
- Requests are sampled every cycle. A request that rises and falls between grants without being selected is lost; the block has no request memory.
- cnt arithmetic is unsigned 4-bit. cnt never exceeds HOLD_MAX-1, so it cannot overflow.

## Timing
- Reset values, applied immediately when rst_n goes low:
  - state=IDLE, sel=0, gnt=0, valid=0, ptr=0, cnt=0, out=0.
- Reset asserted in the middle of a grant drops gnt and valid with no clock edge needed.
- After rst_n deasserts, the first grant occurs on the first rising edge at which req≠0.
- Request-to-grant latency: req sampled high at edge t gives gnt/sel/valid updated at edge t (visible during cycle t+1). Equivalently, one cycle from req rise to gnt.
- Maximum grant length: HOLD_MAX cycles.
- Worst-case wait for a continuously requesting requester: 7·HOLD_MAX cycles.
- out follows sel/valid and data_i combinationally within the same cycle; there is no registered data latency.
- Release caused by a request drop: the owner drops req in cycle c, the release is seen at the edge ending c, and the next owner holds gnt from cycle c+1.

## Structure
- Shared package `mux8_sched_pkg`:
  - N_REQ=8, SEL_W=3, CNT_W=4.
  - State enum {S_IDLE, S_GRANT}.
- One sub-module: `rr_pick8`, a combinational rotate-priority picker.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: any, idx[2:0].
- The output mux is an `always @(*)` case on sel inside the top-level block.

## Test plan
- Reset mid-grant: owner is 5 with valid=1; pull rst_n low between edges -> gnt=0, sel=0, valid=0, out=0 immediately. After release with req=0x01 -> gnt=0x01 at the next edge.
- Full contention: req=0xFF constant, HOLD_MAX=4 -> gnt=0x01 for 4 cycles, then 0x02 ×4, … 0x80 ×4, then 0x01. sel steps 0..7 with no gaps.
- Wraparound and lone requester: only req[3] high for 12 cycles with HOLD_MAX=4 -> gnt=0x08 for all 12 cycles, cnt cycles 0..3. Then req=0x81 after an owner of 7 -> gnt=0x01 next.
- Early release: owner 2, req[2] drops after 2 cycles while req[5]=1 -> gnt changes 0x04 to 0x20 on the next edge, valid stays 1.
- Idle return: owner drops req while req=0 otherwise -> gnt=0, valid=0 next edge. A later req=0x10 is granted after one cycle.
- Data path: data_i=0xA5. Grant to 2 -> out=1; grant to 1 -> out=0; valid=0 -> out=0 regardless of data_i.
